vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19, meaning the VRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the VRAM word width.
REQ-003 SHALL have parameter FRAME_WORDS, default 480000, meaning the number of scan-out words per frame (800x600).
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, meaning the scan-out prefetch depth (power of two).
REQ-005 SHALL have ports clk (in, 1, the single clock) and rst_n (in, 1, asynchronous active-low reset).
REQ-006 SHALL have scan-out read ports: vram_ra0 (out, ADDR_W, VRAM read address) and vram_rd0 (in, DATA_W, VRAM read data, valid 1 cycle after address).
REQ-007 SHALL have the scan-out stream: pix_dout (out, DATA_W), pix_valid (out, 1), pix_ready (in, 1) and frame_start (out, 1, pulse with the word at address 0).
REQ-008 SHALL have the shared write port: vram_wa (out, ADDR_W), vram_wd (out, DATA_W) and vram_we (out, 1).
REQ-009 SHALL have three write requesters, where x is cpu, fill or line: x_req (in, 1), x_addr (in, ADDR_W), x_data (in, DATA_W) and x_gnt (out, 1).

Function
REQ-010 SHALL prefetch: issue a read at vram_ra0 whenever FIFO occupancy plus in-flight reads is less than FIFO_DEPTH, with at most one read issued per cycle.
REQ-011 SHALL push vram_rd0 into the FIFO exactly one cycle after each issued read.
REQ-012 SHALL increment the read address by 1 per issued read and wrap from FRAME_WORDS-1 to 0.
REQ-013 SHALL tag the FIFO entry for address 0 so that frame_start is high in the cycle that word is presented on pix_dout.
REQ-014 SHALL hold pix_valid high while the FIFO is non-empty; a pop occurs only when pix_valid and pix_ready are both high.
REQ-015 SHALL keep pix_dout stable while pix_valid is high and pix_ready is low.
REQ-016 SHALL support a simultaneous push and pop when the FIFO is full or empty, with occupancy unchanged and no data loss.
REQ-017 SHALL arbitrate writes with cpu at fixed highest priority and fill/line at round-robin among themselves.
REQ-018 SHALL keep a round-robin pointer that toggles only when fill or line is granted, and SHALL favour the requester not granted last.
REQ-019 SHALL combinationally assert at most one x_gnt in any cycle; in that same cycle vram_we is 1 and vram_wa/vram_wd carry the granted requester's addr/data.
REQ-020 SHALL drive vram_we to 0 and vram_wa/vram_wd to 0 when no request is pending.
REQ-021 SHALL grant every requester whose x_req is high within 3 cycles, provided cpu is not requesting continuously; cpu starvation of fill/line is permitted.
REQ-022 SHALL assign read and write ports independently; writes never stall scan-out.

Reset
REQ-023 SHALL, while rst_n is low, asynchronously force: read address 0, FIFO empty, in-flight count 0, pix_valid 0, pix_dout 0, frame_start 0, round-robin pointer favouring fill, and all x_gnt 0.
REQ-024 SHALL, on reset assertion mid-frame, discard any in-flight read, which is not pushed after release.
REQ-025 SHALL issue its first read, at address 0, on the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL, with VRAM_ARBITER_STATS_EN defined, add outputs underrun_cnt (32 bits, counts cycles with pix_ready high and pix_valid low, saturating) and wr_stall_cnt (32 bits, counts cycles with fill or line requesting but not granted, saturating), both cleared by reset.
REQ-027 SHALL, without VRAM_ARBITER_STATS_EN, have neither those ports nor the counter logic.

Structure
REQ-028 SHALL take ADDR_W/DATA_W defaults, FRAME_WORDS and the requester index enum (REQ_CPU, REQ_FILL, REQ_LINE) from shared package vram_pkg.
REQ-029 SHALL implement the prefetch FIFO, including the frame-start tag bit, as sub-module vram_scan_fifo (DATA_W+1 wide, FIFO_DEPTH deep, registered occupancy count).

Verification
REQ-030 SHALL verify that with pix_ready held 1 from reset release, vram_ra0 sequences 0,1,2,... and pix_dout equals the model memory at the same addresses, with first pix_valid 2 cycles after release.
REQ-031 SHALL verify that with pix_ready held 0 the bench sees exactly 8 reads issued and then none; one pop then yields exactly one new read.
REQ-032 SHALL verify that with FRAME_WORDS=16 and pix_ready=1, the address wraps 15->0 and frame_start pulses with every 16th word and only then.
REQ-033 SHALL verify that with cpu_req, fill_req and line_req all held 1, the grant sequence is cpu only, every cycle; after cpu drops, fill and line alternate, fill first.
REQ-034 SHALL verify that with fill_req and line_req held 1, grants alternate fill/line every cycle and vram_wa follows the granted addr.
REQ-035 SHALL verify that rst_n pulsed low at word 300 with a read in flight leaves the FIFO empty and pix_valid 0, and that scan-out restarts at address 0.

Source files
------------

// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared widths, frame size and write-requester indices for the VRAM arbiter
package vram_pkg;

  localparam int ADDR_W_DEF      = 19;
  localparam int DATA_W_DEF      = 32;
  localparam int FRAME_WORDS_DEF = 480000;  // 800x600 scan-out words
  localparam int FIFO_DEPTH_DEF  = 8;

  // Write requester index; also used to remember which of fill/line is favoured next.
  typedef enum logic [1:0] {
    REQ_CPU  = 2'd0,
    REQ_FILL = 2'd1,
    REQ_LINE = 2'd2
  } req_idx_e;

endpackage

// File: rtl/vram_scan_fifo.sv
// rtl/vram_scan_fifo.sv - scan-out prefetch FIFO (pixel word plus frame-start tag) with registered occupancy
module vram_scan_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  // A push into a full FIFO is only taken when the same cycle frees a slot.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign count_o = count_q;
  // Empty FIFO presents zero so the consumer never sees stale data or a stale tag.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Next pointers and occupancy from the push/pop pair.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - VRAM scan-out prefetcher and 3-way write arbiter; VRAM_ARBITER_STATS_EN adds stall counters
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] vram_ra0,
  input  logic [DATA_W-1:0] vram_rd0,
  output logic [DATA_W-1:0] pix_dout,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              frame_start,
  output logic [ADDR_W-1:0] vram_wa,
  output logic [DATA_W-1:0] vram_wd,
  output logic              vram_we,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_gnt,
  input  logic              fill_req,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  output logic              fill_gnt,
  input  logic              line_req,
  input  logic [ADDR_W-1:0] line_addr,
  input  logic [DATA_W-1:0] line_data,
  output logic              line_gnt
`ifdef VRAM_ARBITER_STATS_EN
  ,
  output logic [31:0]       underrun_cnt,
  output logic [31:0]       wr_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  // ---------------- scan-out prefetch ----------------
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              inflight_q, inflight_d;
  logic              tag_q, tag_d;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occ_sum;
  logic              issue;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_rdata;

  // Reads already in flight reserve a slot so a full FIFO is never overrun.
  assign occ_sum = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q);
  assign issue   = (occ_sum < (CNT_W + 1)'(FIFO_DEPTH));

  // Read address walk with frame wrap; remember whether the issued read is word 0.
  always_comb begin
    rd_addr_d  = rd_addr_q;
    inflight_d = issue;
    tag_d      = (rd_addr_q == '0);
    if (issue) begin
      rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + ADDR_W'(1);
    end
  end

  // Read issue state; reset drops any in-flight read so it is never pushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q  <= '0;
      inflight_q <= 1'b0;
      tag_q      <= 1'b0;
    end else begin
      rd_addr_q  <= rd_addr_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

  assign vram_ra0 = rd_addr_q;

  vram_scan_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_scan_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .wdata_i ({tag_q, vram_rd0}),
    .pop_i   (pix_valid && pix_ready),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign pix_valid   = !fifo_empty;
  assign pix_dout    = fifo_rdata[DATA_W-1:0];
  assign frame_start = fifo_rdata[DATA_W];

  // ---------------- write arbitration ----------------
  req_idx_e rr_q, rr_d;  // which of fill/line wins the next tie
  req_idx_e sel;
  logic     any_req;
  logic     grant;

  // cpu always wins; fill/line ties go to the favoured one, which then flips.
  always_comb begin
    sel     = REQ_CPU;
    any_req = 1'b1;
    rr_d    = rr_q;
    if (cpu_req)                   sel = REQ_CPU;
    else if (fill_req && line_req) sel = rr_q;
    else if (fill_req)             sel = REQ_FILL;
    else if (line_req)             sel = REQ_LINE;
    else                           any_req = 1'b0;
    if (any_req && sel == REQ_FILL)      rr_d = REQ_LINE;
    else if (any_req && sel == REQ_LINE) rr_d = REQ_FILL;
  end

  // Round-robin pointer; reset favours fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= REQ_FILL;
    else        rr_q <= rr_d;
  end

  // Grants are suppressed while reset is held.
  assign grant = any_req && rst_n;

  // Drive the shared write port from the selected requester, zero when idle.
  always_comb begin
    cpu_gnt  = 1'b0;
    fill_gnt = 1'b0;
    line_gnt = 1'b0;
    vram_we  = grant;
    vram_wa  = '0;
    vram_wd  = '0;
    if (grant) begin
      case (sel)
        REQ_CPU: begin
          cpu_gnt = 1'b1;
          vram_wa = cpu_addr;
          vram_wd = cpu_data;
        end
        REQ_FILL: begin
          fill_gnt = 1'b1;
          vram_wa  = fill_addr;
          vram_wd  = fill_data;
        end
        REQ_LINE: begin
          line_gnt = 1'b1;
          vram_wa  = line_addr;
          vram_wd  = line_data;
        end
        default: begin
          vram_wa = '0;
          vram_wd = '0;
        end
      endcase
    end
  end

`ifdef VRAM_ARBITER_STATS_EN
  logic [31:0] underrun_q, wr_stall_q;

  // Saturating counts of starved scan-out cycles and stalled fill/line cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_q <= '0;
      wr_stall_q <= '0;
    end else begin
      if (pix_ready && !pix_valid && underrun_q != '1) underrun_q <= underrun_q + 32'd1;
      if ((fill_req || line_req) && !(fill_gnt || line_gnt) && wr_stall_q != '1)
        wr_stall_q <= wr_stall_q + 32'd1;
    end
  end

  assign underrun_cnt = underrun_q;
  assign wr_stall_cnt = wr_stall_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter (default frame and 16-word frame instances)
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int AW  = 19;
  localparam int DW  = 32;
  localparam int FW0 = 480000;
  localparam int FW1 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          pix_ready;
  logic [AW-1:0] ra0, ra16;
  logic [DW-1:0] rd0, rd16;
  logic [DW-1:0] dout, dout16;
  logic          valid, valid16, fs, fs16;
  logic [AW-1:0] wa, wa16;
  logic [DW-1:0] wd, wd16;
  logic          we, we16;
  logic          cpu_req, fill_req, line_req;
  logic [AW-1:0] cpu_addr, fill_addr, line_addr;
  logic [DW-1:0] cpu_data, fill_data, line_data;
  logic          cpu_gnt, fill_gnt, line_gnt;
  logic          c16, f16, l16;
`ifdef VRAM_ARBITER_STATS_EN
  logic [31:0]   un0, ws0, un16, ws16;
`endif

  int vectors = 0;
  int fails   = 0;

  vram_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .vram_ra0(ra0), .vram_rd0(rd0),
    .pix_dout(dout), .pix_valid(valid), .pix_ready(pix_ready), .frame_start(fs),
    .vram_wa(wa), .vram_wd(wd), .vram_we(we),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_gnt(cpu_gnt),
    .fill_req(fill_req), .fill_addr(fill_addr), .fill_data(fill_data), .fill_gnt(fill_gnt),
    .line_req(line_req), .line_addr(line_addr), .line_data(line_data), .line_gnt(line_gnt)
`ifdef VRAM_ARBITER_STATS_EN
    , .underrun_cnt(un0), .wr_stall_cnt(ws0)
`endif
  );

  vram_arbiter #(.FRAME_WORDS(FW1)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .vram_ra0(ra16), .vram_rd0(rd16),
    .pix_dout(dout16), .pix_valid(valid16), .pix_ready(1'b1), .frame_start(fs16),
    .vram_wa(wa16), .vram_wd(wd16), .vram_we(we16),
    .cpu_req(1'b0), .cpu_addr('0), .cpu_data('0), .cpu_gnt(c16),
    .fill_req(1'b0), .fill_addr('0), .fill_data('0), .fill_gnt(f16),
    .line_req(1'b0), .line_addr('0), .line_data('0), .line_gnt(l16)
`ifdef VRAM_ARBITER_STATS_EN
    , .underrun_cnt(un16), .wr_stall_cnt(ws16)
`endif
  );

  function automatic logic [DW-1:0] word_of(input int a);
    logic [31:0] av;
    av = 32'(a);
    return 32'hC0DE_0000 ^ (av * 32'h0001_0101);
  endfunction

  // VRAM read side: data appears one cycle after the address.
  always @(posedge clk) begin
    rd0  <= word_of(int'(ra0));
    rd16 <= word_of(int'(ra16));
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: k-th word popped since reset is word_of(k mod frame); grants by priority + alternation.
  int       exp0  = 0;
  int       exp16 = 0;
  req_idx_e rr_m  = REQ_FILL;

  always @(negedge clk) begin
    int g;
    if (!rst_n) begin
      chk("rst_ra0", ra0, 0);
      chk("rst_valid", valid, 0);
      chk("rst_dout", dout, 0);
      chk("rst_fs", fs, 0);
      chk("rst_valid16", valid16, 0);
      chk("rst_gnts", {cpu_gnt, fill_gnt, line_gnt}, 0);
      chk("rst_we", we, 0);
      exp0  = 0;
      exp16 = 0;
      rr_m  = REQ_FILL;
    end else begin
      if (valid) begin
        chk("m_dout", dout, word_of(exp0));
        chk("m_fs", fs, (exp0 == 0));
        if (pix_ready) exp0 = (exp0 + 1) % FW0;
      end else begin
        chk("m_fs_idle", fs, 0);
      end
      if (valid16) begin
        chk("m_dout16", dout16, word_of(exp16));
        chk("m_fs16", fs16, (exp16 == 0));
        exp16 = (exp16 + 1) % FW1;
      end
      chk("m_we16", we16, 0);
      if (cpu_req)                   g = 1;
      else if (fill_req && line_req) g = (rr_m == REQ_FILL) ? 2 : 3;
      else if (fill_req)             g = 2;
      else if (line_req)             g = 3;
      else                           g = 0;
      chk("m_gnts", {cpu_gnt, fill_gnt, line_gnt}, {g == 1, g == 2, g == 3});
      chk("m_we", we, (g != 0));
      case (g)
        1:       begin chk("m_wa", wa, cpu_addr);  chk("m_wd", wd, cpu_data);  end
        2:       begin chk("m_wa", wa, fill_addr); chk("m_wd", wd, fill_data); end
        3:       begin chk("m_wa", wa, line_addr); chk("m_wd", wd, line_data); end
        default: begin chk("m_wa", wa, 0);         chk("m_wd", wd, 0);         end
      endcase
      if (g == 2) rr_m = REQ_LINE;
      if (g == 3) rr_m = REQ_FILL;
    end
  end

  // Release reset and pin the first two cycles of scan-out.
  task automatic release_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    chk("rel_ra_e0", ra0, 0);
    chk("rel_valid_e0", valid, 0);
    @(posedge clk); #1;
    chk("rel_ra_e1", ra0, 1);
    chk("rel_ra16_e1", ra16, 1);
    chk("rel_valid_e1", valid, 0);
    @(posedge clk); #1;
    chk("rel_ra_e2", ra0, 2);
    chk("rel_valid_e2", valid, 1);
    chk("rel_dout_e2", dout, 32'hC0DE_0000);
    chk("rel_fs_e2", fs, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; pix_ready = 1'b1;
    cpu_req = 0; fill_req = 0; line_req = 0;
    cpu_addr = '0; fill_addr = '0; line_addr = '0;
    cpu_data = '0; fill_data = '0; line_data = '0;
    repeat (3) @(posedge clk);

    // Streaming with pix_ready high, plus 16-word frame wrap.
    release_reset();
    for (int e = 3; e <= 18; e++) begin
      @(posedge clk); #1;
      if (e == 10) chk("stream_ra_e10", ra0, 10);
      if (e == 15) chk("wrap_ra16_e15", ra16, 15);
      if (e == 16) chk("wrap_ra16_e16", ra16, 0);
      if (e == 17) begin
        chk("wrap_fs16_w15", fs16, 0);
        chk("wrap_dout16_w15", dout16, 32'hC0D1_0F0F);
      end
      if (e == 18) begin
        chk("wrap_fs16_w16", fs16, 1);
        chk("wrap_dout16_w16", dout16, 32'hC0DE_0000);
      end
    end

    // Reset mid-frame at word 300 with a read in flight.
    for (int n = 0; n < 1000 && exp0 < 300; n++) begin
      @(negedge clk); #1;
    end
    chk("reach_word300", exp0, 300);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", valid, 0);
    chk("midrst_dout", dout, 0);
    chk("midrst_ra", ra0, 0);
    @(posedge clk); @(posedge clk);
    pix_ready = 1'b0;

    // Backpressure: 8 reads then none; one pop gives one more read.
    release_reset();
    repeat (20) @(posedge clk);
    #1;
    chk("bp_ra_full", ra0, 8);
    chk("bp_valid", valid, 1);
    chk("bp_dout_hold", dout, 32'hC0DE_0000);
    pix_ready = 1'b1;
    @(posedge clk); #1 pix_ready = 1'b0;
    chk("bp_dout_after_pop", dout, 32'hC0DF_0101);
    chk("bp_ra_after_pop", ra0, 8);
    @(posedge clk); #1;
    chk("bp_ra_one_more", ra0, 9);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_ra_stays", ra0, 9);

    // Write arbitration from a clean reset.
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk);
    release_reset();
    cpu_addr  = 19'h00100; cpu_data  = 32'hAAAA_0001;
    fill_addr = 19'h00200; fill_data = 32'hBBBB_0002;
    line_addr = 19'h00300; line_data = 32'hCCCC_0003;
    cpu_req = 1; fill_req = 1; line_req = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cpu_prio_gnts", {cpu_gnt, fill_gnt, line_gnt}, 3'b100);
      chk("cpu_prio_wa", wa, 19'h00100);
      chk("cpu_prio_wd", wd, 32'hAAAA_0001);
      @(posedge clk); #1;
    end
    cpu_req = 0;
    for (int i = 0; i < 6; i++) begin
      fill_addr = 19'h00200 + 19'(i);
      line_addr = 19'h00300 + 19'(i);
      #1;
      chk("rr_gnts", {cpu_gnt, fill_gnt, line_gnt}, (i % 2 == 0) ? 3'b010 : 3'b001);
      chk("rr_wa", wa, (i % 2 == 0) ? 19'h00200 + 19'(i) : 19'h00300 + 19'(i));
      @(posedge clk); #1;
    end
    fill_req = 0;
    #1;
    chk("line_only_gnt", {cpu_gnt, fill_gnt, line_gnt}, 3'b001);
    @(posedge clk); #1;
    fill_req = 1;
    #1;
    chk("rr_after_line_gnt", {cpu_gnt, fill_gnt, line_gnt}, 3'b010);
    @(posedge clk); #1;
    fill_req = 0; line_req = 0;
    #1;
    chk("idle_we", we, 0);
    chk("idle_wa", wa, 0);
    chk("idle_wd", wd, 0);
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
